// File: rtl/mul_div_sequencer.sv
// mul_div_sequencer
// Iterative RV32M multiply/divide unit that sits next to the single-cycle ALU
// in EX. Multiplies by shift-add and divides by restoring division, one bit
// per cycle. It stalls the pipeline while it works and reports completion
// with a one-cycle Done pulse.
//
// Ports
//   clk     : clock, rising edge
//   reset   : asynchronous, active-high; aborts any operation in flight
//   Start   : M-extension op valid in EX this cycle
//   Funct3  : 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU,
//             100 DIV, 101 DIVU, 110 REM, 111 REMU
//   SrcA    : rs1 (multiplicand / dividend)
//   SrcB    : rs2 (multiplier / divisor)
//   Result  : registered result, valid while Done=1, held until next result
//   Busy    : unit not idle
//   Done    : one-cycle completion pulse
//   Stall   : freezes IF/ID/EX from the Start cycle through the FIX cycle
//
// Build option
//   MDU_ZERO_SKIP_EN : when defined, a zero multiplier (MUL*) or a zero
//   dividend (DIV*/REM* with a non-zero divisor) skips the iteration. Results
//   are the same with or without it; only latency changes.
module mul_div_sequencer #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Start,
    input  logic [2:0]            Funct3,
    input  logic [DATA_WIDTH-1:0] SrcA,
    input  logic [DATA_WIDTH-1:0] SrcB,
    output logic [DATA_WIDTH-1:0] Result,
    output logic                  Busy,
    output logic                  Done,
    output logic                  Stall
);

    localparam int N  = DATA_WIDTH;
    localparam int CW = $clog2(N);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]     state_reg;
    logic [CW-1:0]  count_reg;
    logic [2:0]     f3_reg;
    logic           neg_reg;
    // Multiply: {partial product, multiplier}. Divide: {remainder, dividend/quotient}.
    logic [2*N-1:0] acc_reg;
    logic [N-1:0]   opb_reg;
    logic [N-1:0]   result_reg;

    // Operand conditioning at accept
    logic           a_signed, b_signed, sign_a, sign_b, neg_next;
    logic [N-1:0]   mag_a, mag_b;
    logic           div_zero, div_ovf, zero_skip, fast_path;
    logic [2*N-1:0] fast_acc;

    always_comb begin
        a_signed = 1'b0;
        b_signed = 1'b0;
        case (Funct3)
            3'b000, 3'b001, 3'b100, 3'b110: begin a_signed = 1'b1; b_signed = 1'b1; end
            3'b010:                         a_signed = 1'b1;
            default:                        ;
        endcase
        sign_a   = a_signed & SrcA[N-1];
        sign_b   = b_signed & SrcB[N-1];
        mag_a    = sign_a ? -SrcA : SrcA;
        mag_b    = sign_b ? -SrcB : SrcB;
        // REM follows the dividend; everything else is signA^signB
        // (unsigned ops have both signs cleared, MULHSU has sign_b cleared).
        neg_next = (Funct3 == 3'b110) ? sign_a : (sign_a ^ sign_b);

        div_zero = Funct3[2] && (SrcB == '0);
        div_ovf  = Funct3[2] && !Funct3[0] && (SrcA == {1'b1, {(N-1){1'b0}}}) && (SrcB == '1);
`ifdef MDU_ZERO_SKIP_EN
        zero_skip = (!Funct3[2] && (SrcB == '0)) || (Funct3[2] && (SrcA == '0) && (SrcB != '0));
`else
        zero_skip = 1'b0;
`endif
        fast_path = div_zero || div_ovf || zero_skip;

        // Fast-path results are preloaded as {remainder, quotient} so FIX can
        // width-select them exactly like an iterated result (sign fix disabled).
        if (div_zero)
            fast_acc = {SrcA, {N{1'b1}}};
        else if (div_ovf)
            fast_acc = {{N{1'b0}}, 1'b1, {(N-1){1'b0}}};
        else
            fast_acc = '0;
    end

    // One iteration step
    logic [N:0]     mul_sum;
    logic [2*N-1:0] mul_next;
    logic [N:0]     div_shift, div_trial;
    logic           div_ge;
    logic [2*N-1:0] div_next;

    always_comb begin
        mul_sum  = {1'b0, acc_reg[2*N-1:N]} + {1'b0, opb_reg};
        mul_next = acc_reg[0] ? {mul_sum, acc_reg[N-1:1]} : {1'b0, acc_reg[2*N-1:1]};

        div_shift = acc_reg[2*N-1:N-1];
        div_trial = div_shift - {1'b0, opb_reg};
        // Remainder stays below the divisor, so a set top bit of the shifted
        // value always means it is large enough; otherwise the borrow decides.
        div_ge    = div_shift[N] | ~div_trial[N];
        div_next  = {(div_ge ? div_trial[N-1:0] : div_shift[N-1:0]), acc_reg[N-2:0], div_ge};
    end

    // Sign correction and width select
    logic [2*N-1:0] prod_fix;
    logic [N-1:0]   div_sel, div_fix, fix_result;

    always_comb begin
        prod_fix = neg_reg ? -acc_reg : acc_reg;
        div_sel  = f3_reg[1] ? acc_reg[2*N-1:N] : acc_reg[N-1:0];
        div_fix  = neg_reg ? -div_sel : div_sel;
        case (f3_reg)
            3'b000:                 fix_result = prod_fix[N-1:0];
            3'b001, 3'b010, 3'b011: fix_result = prod_fix[2*N-1:N];
            default:                fix_result = div_fix;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= IDLE;
            count_reg  <= '0;
            f3_reg     <= '0;
            neg_reg    <= 1'b0;
            acc_reg    <= '0;
            opb_reg    <= '0;
            result_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (Start) begin
                        f3_reg <= Funct3;
                        if (fast_path) begin
                            neg_reg   <= 1'b0;
                            acc_reg   <= fast_acc;
                            opb_reg   <= '0;
                            state_reg <= FIX;
                        end else begin
                            neg_reg   <= neg_next;
                            acc_reg   <= {{N{1'b0}}, mag_a};
                            opb_reg   <= mag_b;
                            count_reg <= CW'(N - 1);
                            state_reg <= CALC;
                        end
                    end
                end
                CALC: begin
                    acc_reg   <= f3_reg[2] ? div_next : mul_next;
                    count_reg <= count_reg - 1'b1;
                    if (count_reg == '0)
                        state_reg <= FIX;
                end
                FIX: begin
                    result_reg <= fix_result;
                    state_reg  <= DONE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign Result = result_reg;
    assign Busy   = (state_reg != IDLE);
    assign Done   = (state_reg == DONE);
    assign Stall  = ((state_reg == IDLE) && Start) || (state_reg == CALC) || (state_reg == FIX);

endmodule

// File: tb/tb_mul_div_sequencer.sv
// Testbench for mul_div_sequencer: directed RV32M cases, reset behaviour,
// back-to-back issue and randomized operations against an arithmetic model.
module tb_mul_div_sequencer;

    localparam int N = 32;

    logic          clk;
    logic          reset;
    logic          Start;
    logic [2:0]    Funct3;
    logic [N-1:0]  SrcA;
    logic [N-1:0]  SrcB;
    logic [N-1:0]  Result;
    logic          Busy;
    logic          Done;
    logic          Stall;

    int checks   = 0;
    int failures = 0;

    mul_div_sequencer #(.DATA_WIDTH(N)) dut (
        .clk    (clk),
        .reset  (reset),
        .Start  (Start),
        .Funct3 (Funct3),
        .SrcA   (SrcA),
        .SrcB   (SrcB),
        .Result (Result),
        .Busy   (Busy),
        .Done   (Done),
        .Stall  (Stall)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // RV32M semantics written directly with 64-bit arithmetic.
    function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, sp;
        logic [63:0] up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (f3)
            3'd0: begin sp = sa * sb; ref_result = sp[31:0]; end
            3'd1: begin sp = sa * sb; ref_result = sp[63:32]; end
            3'd2: begin sp = sa * longint'({32'd0, b}); ref_result = sp[63:32]; end
            3'd3: begin up = {32'd0, a} * {32'd0, b}; ref_result = up[63:32]; end
            3'd4: begin
                if (b == 0)                                  ref_result = 32'hFFFF_FFFF;
                else if (a == 32'h8000_0000 && b == '1)      ref_result = 32'h8000_0000;
                else                                         ref_result = $signed(a) / $signed(b);
            end
            3'd5: ref_result = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0)                                  ref_result = a;
                else if (a == 32'h8000_0000 && b == '1)      ref_result = 32'd0;
                else                                         ref_result = $signed(a) % $signed(b);
            end
            default: ref_result = (b == 0) ? a : a % b;
        endcase
    endfunction

    // Cycles from the accept edge to the Done cycle.
    function automatic int exp_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        bit fast;
        fast = f3[2] && ((b == 0) || (!f3[0] && a == 32'h8000_0000 && b == '1));
`ifdef MDU_ZERO_SKIP_EN
        if ((!f3[2] && b == 0) || (f3[2] && a == 0 && b != 0))
            fast = 1'b1;
`endif
        exp_lat = fast ? 2 : N + 2;
    endfunction

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 6))
            0: rand_operand = 32'd0;
            1: rand_operand = 32'd1;
            2: rand_operand = 32'hFFFF_FFFF;
            3: rand_operand = 32'h8000_0000;
            4: rand_operand = $urandom_range(0, 15);
            default: rand_operand = $urandom;
        endcase
    endfunction

    // Issues one op from IDLE and follows it to Done.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input bit keep_start, input string tag);
        int          lat;
        int          done_cyc;
        bit          stall_bad;
        logic [31:0] exp;
        lat       = exp_lat(f3, a, b);
        exp       = ref_result(f3, a, b);
        done_cyc  = -1;
        stall_bad = 1'b0;
        @(posedge clk);
        #1;
        Start  = 1'b1;
        Funct3 = f3;
        SrcA   = a;
        SrcB   = b;
        @(negedge clk);
        check({tag, "_idle_busy"}, 64'(Busy), 64'd0);
        check({tag, "_start_stall"}, 64'(Stall), 64'd1);
        @(posedge clk);
        #1;
        if (!keep_start) begin
            // Inputs after accept must have no effect.
            Start  = 1'b0;
            Funct3 = 3'($urandom);
            SrcA   = $urandom;
            SrcB   = $urandom;
        end
        for (int cyc = 1; cyc <= N + 6; cyc++) begin
            @(negedge clk);
            if (Done) begin
                done_cyc = cyc;
                break;
            end
            if (Stall !== 1'b1 || Busy !== 1'b1)
                stall_bad = 1'b1;
        end
        check({tag, "_done_cycle"}, 64'(done_cyc), 64'(lat));
        check({tag, "_result"}, 64'(Result), 64'(exp));
        check({tag, "_stall_during_op"}, 64'(stall_bad), 64'd0);
        if (done_cyc > 0) begin
            check({tag, "_done_stall"}, 64'(Stall), 64'd0);
            check({tag, "_done_busy"}, 64'(Busy), 64'd1);
        end
        $display("op %s f3=%0d a=%h b=%h result=%h exp=%h done_cycle=%0d exp_cycle=%0d",
                 tag, f3, a, b, Result, exp, done_cyc, lat);
    endtask

    initial begin
        bit saw_done;
        reset  = 1'b1;
        Start  = 1'b0;
        Funct3 = 3'd0;
        SrcA   = '0;
        SrcB   = '0;
        #12;
        check("rst_result", 64'(Result), 64'd0);
        check("rst_busy", 64'(Busy), 64'd0);
        check("rst_done", 64'(Done), 64'd0);
        check("rst_stall_idle", 64'(Stall), 64'd0);
        Start = 1'b1;
        #1;
        check("rst_stall_follows_start", 64'(Stall), 64'd1);
        Start = 1'b0;
        #1;
        check("rst_stall_drops", 64'(Stall), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 1'b0, "mul_7_m3");
        run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 1'b0, "mulh_min_min");
        run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "mulhsu_m1");
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "mulhu_max");
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 1'b0, "div_m7_2");
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 1'b0, "rem_m7_2");
        run_op(3'd5, 32'd100, 32'd7, 1'b0, "divu_100_7");
        run_op(3'd7, 32'd100, 32'd7, 1'b0, "remu_100_7");
        run_op(3'd5, 32'd5, 32'd0, 1'b0, "divu_by_zero");
        run_op(3'd6, 32'd5, 32'd0, 1'b0, "rem_by_zero");
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_overflow");
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "rem_overflow");
        run_op(3'd0, 32'd9, 32'd0, 1'b0, "mul_9_0");
        run_op(3'd4, 32'd0, 32'd5, 1'b0, "div_0_5");

        // Abort a DIV in its tenth CALC cycle.
        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 1'b0, "pre_abort_mul");
        @(posedge clk);
        #1;
        Start  = 1'b1;
        Funct3 = 3'd4;
        SrcA   = 32'd1000;
        SrcB   = 32'd7;
        @(posedge clk);
        #1;
        Start = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("abort_busy", 64'(Busy), 64'd0);
        check("abort_result", 64'(Result), 64'd0);
        check("abort_done", 64'(Done), 64'd0);
        @(posedge clk);
        #1;
        reset    = 1'b0;
        saw_done = 1'b0;
        repeat (N + 4) begin
            @(negedge clk);
            if (Done) saw_done = 1'b1;
        end
        check("abort_no_done", 64'(saw_done), 64'd0);
        check("abort_idle", 64'(Busy), 64'd0);
        $display("op abort_div reset in CALC cycle 10 busy=%b result=%h", Busy, Result);
        run_op(3'd0, 32'd3, 32'd4, 1'b0, "mul_3_4_after_abort");

        // Start held high through the whole first op.
        run_op(3'd0, 32'd5, 32'd6, 1'b1, "b2b_first");
        run_op(3'd0, 32'h1234_5678, 32'h0000_0010, 1'b0, "b2b_second");

        for (int i = 0; i < 40; i++) begin
            logic [2:0]  f3;
            logic [31:0] a, b;
            f3 = 3'($urandom_range(0, 7));
            a  = rand_operand();
            b  = rand_operand();
            run_op(f3, a, b, bit'($urandom_range(0, 1)), $sformatf("rand%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "simulation time limit reached");
    end

endmodule
